// File: rtl/rv32m_muldiv_if.sv
// Request/response bundle between the core and the RV32M multiply/divide unit.
//   start/funct3/rs1_data/rs2_data/rd_addr : request from the core
//   busy/done/result/rd_out                : status and register-file write port
// master = core side, slave = execution unit side.
interface rv32m_muldiv_if;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [4:0]  rd_addr;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   modport master (
      output start, funct3, rs1_data, rs2_data, rd_addr,
      input  busy, done, result, rd_out
   );

   modport slave (
      input  start, funct3, rs1_data, rs2_data, rd_addr,
      output busy, done, result, rd_out
   );
endinterface

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide unit (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
// 32-step shift-add multiply and restoring divide on operand magnitudes, sign fixed at the end.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - slave side of rv32m_muldiv_if: start/funct3/rs1_data/rs2_data/rd_addr in,
//          busy (stall), done (one-cycle write strobe), result, rd_out out.
module rv32m_muldiv (
   input logic           clk,
   input logic           rst,
   rv32m_muldiv_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [2:0]  op_q, op_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [63:0] acc_q, acc_d;
   logic        neg_q, neg_d;
   logic        rem_neg_q, rem_neg_d;
   logic [31:0] result_q, result_d;

   logic        accept, is_div, sgn1, sgn2, div_zero, div_ovf, special;
   logic [31:0] mag1, mag2, special_res;
   logic [32:0] mul_sum;
   logic [32:0] shifted;
   logic [31:0] diff;
   logic [63:0] mul_next, div_next, step, prod;
   logic [31:0] quot, rem, fin_res;

   // Request decode: sign flags, magnitudes and the cases that skip iteration
   always_comb begin
      accept = bus.start && (state_q != StCalc);
      is_div = bus.funct3[2];
      sgn1   = 1'b0;
      sgn2   = 1'b0;
      unique case (bus.funct3)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            sgn1 = bus.rs1_data[31];
            sgn2 = bus.rs2_data[31];
         end
         3'b010: sgn1 = bus.rs1_data[31];
         default: ;
      endcase
      mag1     = sgn1 ? -bus.rs1_data : bus.rs1_data;
      mag2     = sgn2 ? -bus.rs2_data : bus.rs2_data;
      div_zero = is_div && (bus.rs2_data == 32'd0);
      div_ovf  = is_div && !bus.funct3[0] && (bus.rs1_data == 32'h8000_0000)
                 && (bus.rs2_data == 32'hFFFF_FFFF);
      special  = div_zero || div_ovf;
      if (div_zero) begin
         special_res = bus.funct3[1] ? bus.rs1_data : 32'hFFFF_FFFF;
      end else begin
         special_res = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
      end
   end

   // One iteration of either datapath.
   // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
   // Divide:   acc = {partial remainder, dividend/quotient bits}, shifted left each step.
   always_comb begin
      mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
      mul_next = {mul_sum, acc_q[31:1]};
      shifted  = {acc_q[63:32], acc_q[31]};
      // Remainder stays below the divisor, so a 32-bit difference is exact when no borrow
      diff     = shifted[31:0] - b_q;
      if (shifted >= {1'b0, b_q}) begin
         div_next = {diff, acc_q[30:0], 1'b1};
      end else begin
         div_next = {shifted[31:0], acc_q[30:0], 1'b0};
      end
      step = op_q[2] ? div_next : mul_next;
      prod = neg_q ? -step : step;
      quot = step[31:0];
      rem  = step[63:32];
      unique case (op_q)
         3'b000:                 fin_res = prod[31:0];
         3'b001, 3'b010, 3'b011: fin_res = prod[63:32];
         3'b100, 3'b101:         fin_res = neg_q ? -quot : quot;
         default:                fin_res = rem_neg_q ? -rem : rem;
      endcase
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               state_d = special ? StDone : StCalc;
            end else begin
               state_d = StIdle;
            end
         end
         StCalc: begin
            if (cnt_q == 5'd31) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM: outputs
   always_comb begin
      bus.busy   = (state_q == StCalc);
      bus.done   = (state_q == StDone);
      bus.result = result_q;
      bus.rd_out = rd_q;
   end

   // Datapath next-state
   always_comb begin
      cnt_d     = cnt_q;
      op_d      = op_q;
      rd_d      = rd_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      result_d  = result_q;
      if (accept) begin
         cnt_d     = 5'd0;
         op_d      = bus.funct3;
         rd_d      = bus.rd_addr;
         a_d       = mag1;
         b_d       = mag2;
         acc_d     = is_div ? {32'd0, mag1} : {32'd0, mag2};
         neg_d     = sgn1 ^ sgn2;
         rem_neg_d = sgn1;
         if (special) begin
            result_d = special_res;
         end
      end else if (state_q == StCalc) begin
         acc_d = step;
         cnt_d = cnt_q + 5'd1;
         if (cnt_q == 5'd31) begin
            result_d = fin_res;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= 5'd0;
         op_q      <= 3'd0;
         rd_q      <= 5'd0;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         acc_q     <= 64'd0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         result_q  <= 32'd0;
      end else begin
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         result_q  <= result_d;
      end
   end

endmodule

// File: tb/tb_rv32m_muldiv.sv
module tb_rv32m_muldiv;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   rv32m_muldiv_if bus ();

   rv32m_muldiv u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference: plain 64-bit arithmetic following the RV32M definitions
   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
      logic signed [63:0] sa, sb, ub;
      logic [63:0]        ua, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      p  = 64'd0;
      case (f)
         3'd0: p = sa * sb;
         3'd1: begin p = sa * sb; p = p >> 32; end
         3'd2: begin p = sa * ub; p = p >> 32; end
         3'd3: begin p = ua * {32'd0, b}; p = p >> 32; end
         3'd4: begin
            if (b == 0) p = 64'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 64'h8000_0000;
            else p = sa / sb;
         end
         3'd5: p = (b == 0) ? 64'hFFFF_FFFF : ua / {32'd0, b};
         3'd6: begin
            if (b == 0) p = ua;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 64'd0;
            else p = sa % sb;
         end
         default: p = (b == 0) ? ua : ua % {32'd0, b};
      endcase
      return p[31:0];
   endfunction

   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b);
      if (f[2] && b == 0) return 1;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Presents a request at a falling edge; returns just after the accepting rising edge
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.funct3   = f;
      bus.rs1_data = a;
      bus.rs2_data = b;
      bus.rd_addr  = rd;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // Counts falling edges until done; lat = -1 if the budget runs out
   task automatic wait_done(output logic [31:0] res, output logic [4:0] rdo, output int lat,
                            output bit busy_seen);
      res = '0;
      rdo = '0;
      lat = -1;
      busy_seen = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) busy_seen = 1'b1;
         if (bus.done === 1'b1) begin
            lat = i;
            res = bus.result;
            rdo = bus.rd_out;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done} !== 2'b00) begin
         errors++;
         $display("FAIL reset_flags busy/done=%b required 00", {bus.busy, bus.done});
      end
      checks++;
      if (bus.result !== 32'd0 || bus.rd_out !== 5'd0) begin
         errors++;
         $display("FAIL reset_regs result=%h rd_out=%0d required 0/0", bus.result, bus.rd_out);
      end
   endtask

   task automatic test_directed();
      logic [2:0]  f[14]  = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6,
                              3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6, 3'd5};
      logic [31:0] a[14]  = '{32'd7, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                              32'h8000_0000, 32'h8000_0000, 32'd9};
      logic [31:0] b[14]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
      logic [31:0] exp[14] = '{32'hFFFF_FFEB, 32'd6, 32'h4000_0000, 32'hFFFF_FFFF,
                               32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                               32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
      int          elat[14] = '{33, 33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 1};
      logic [31:0] res;
      logic [4:0]  rdo;
      int          lat;
      bit          bsy;
      for (int i = 0; i < 14; i++) begin
         issue(f[i], a[i], b[i], 5'(i + 3));
         wait_done(res, rdo, lat, bsy);
         checks++;
         if (res !== exp[i]) begin
            errors++;
            $display("FAIL directed_result[%0d] got %h required %h", i, res, exp[i]);
         end
         checks++;
         if (lat !== elat[i] || rdo !== 5'(i + 3)) begin
            errors++;
            $display("FAIL directed_timing[%0d] lat=%0d rd=%0d required lat=%0d rd=%0d",
                     i, lat, rdo, elat[i], i + 3);
         end
         if (elat[i] == 1) begin
            checks++;
            if (bsy !== 1'b0) begin
               errors++;
               $display("FAIL special_busy[%0d] busy seen=%b required 0", i, bsy);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] corner[6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                                 32'd2};
      logic [31:0] a, b, res;
      logic [2:0]  f;
      logic [4:0]  rd, rdo;
      int          lat;
      bit          bsy;
      for (int i = 0; i < 40; i++) begin
         f  = 3'($urandom_range(0, 7));
         rd = 5'($urandom);
         a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         case ($urandom_range(0, 3))
            0: b = corner[$urandom_range(0, 5)];
            1: b = 32'($urandom_range(1, 300));
            default: b = $urandom;
         endcase
         issue(f, a, b, rd);
         wait_done(res, rdo, lat, bsy);
         checks++;
         if (res !== ref_op(f, a, b) || rdo !== rd) begin
            errors++;
            $display("FAIL random[%0d] f=%0d a=%h b=%h got %h rd %0d required %h rd %0d",
                     i, f, a, b, res, rdo, ref_op(f, a, b), rd);
         end
         checks++;
         if (lat !== ref_lat(f, a, b)) begin
            errors++;
            $display("FAIL random_latency[%0d] got %0d required %0d", i, lat, ref_lat(f, a, b));
         end
      end
   endtask

   task automatic test_ignore_in_calc();
      logic [31:0] res;
      logic [4:0]  rdo;
      int          lat, extra;
      bit          bsy;
      issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11);
      repeat (5) @(negedge clk);
      bus.start    = 1'b1;
      bus.funct3   = 3'd5;
      bus.rs1_data = 32'd1000;
      bus.rs2_data = 32'd0;
      bus.rd_addr  = 5'd22;
      @(posedge clk);
      #1 bus.start = 1'b0;
      bus.rs1_data = 32'hDEAD_BEEF;
      wait_done(res, rdo, lat, bsy);
      checks++;
      if (res !== ref_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0) || rdo !== 5'd11) begin
         errors++;
         $display("FAIL ignore_result got %h rd %0d required %h rd 11", res, rdo,
                  ref_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0));
      end
      checks++;
      if (lat !== 28) begin
         errors++;
         $display("FAIL ignore_latency got %0d required 28", lat);
      end
      extra = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("FAIL ignore_queued activity cycles=%0d required 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res;
      logic [4:0]  rdo;
      int          lat;
      bit          bsy;
      issue(3'd4, 32'hFFFF_0000, 32'd37, 5'd7);
      wait_done(res, rdo, lat, bsy);
      checks++;
      if (res !== ref_op(3'd4, 32'hFFFF_0000, 32'd37) || lat !== 33) begin
         errors++;
         $display("FAIL b2b_first got %h lat %0d required %h lat 33", res, lat,
                  ref_op(3'd4, 32'hFFFF_0000, 32'd37));
      end
      // still in the done cycle: issue the next op immediately
      bus.start    = 1'b1;
      bus.funct3   = 3'd2;
      bus.rs1_data = 32'hFFFF_FFF0;
      bus.rs2_data = 32'hF000_0001;
      bus.rd_addr  = 5'd19;
      @(posedge clk);
      #1 bus.start = 1'b0;
      checks++;
      if ({bus.busy, bus.done} !== 2'b10) begin
         errors++;
         $display("FAIL b2b_busy_rise busy/done=%b required 10", {bus.busy, bus.done});
      end
      wait_done(res, rdo, lat, bsy);
      checks++;
      if (res !== ref_op(3'd2, 32'hFFFF_FFF0, 32'hF000_0001) || rdo !== 5'd19 || lat !== 33) begin
         errors++;
         $display("FAIL b2b_second got %h rd %0d lat %0d required %h rd 19 lat 33", res, rdo,
                  lat, ref_op(3'd2, 32'hFFFF_FFF0, 32'hF000_0001));
      end
   endtask

   task automatic test_reset_midop();
      logic [31:0] res;
      logic [4:0]  rdo;
      int          lat, seen;
      bit          bsy;
      issue(3'd4, 32'd1000, 32'd3, 5'd9);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if ({bus.busy, bus.done} !== 2'b00 || bus.result !== 32'd0 || bus.rd_out !== 5'd0) begin
         errors++;
         $display("FAIL midop_reset busy/done=%b result=%h rd=%0d required 00/0/0",
                  {bus.busy, bus.done}, bus.result, bus.rd_out);
      end
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL midop_no_done pulses=%0d required 0", seen);
      end
      issue(3'd7, 32'd1000, 32'd3, 5'd30);
      wait_done(res, rdo, lat, bsy);
      checks++;
      if (res !== 32'd1 || rdo !== 5'd30 || lat !== 33) begin
         errors++;
         $display("FAIL after_reset got %h rd %0d lat %0d required 1 rd 30 lat 33",
                  res, rdo, lat);
      end
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.funct3   = 3'd0;
      bus.rs1_data = 32'd0;
      bus.rs2_data = 32'd0;
      bus.rd_addr  = 5'd0;
      test_reset();
      test_directed();
      test_random();
      test_ignore_in_calc();
      test_back_to_back();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rv32m_muldiv.md
# rv32m_muldiv

Iterative RV32M multiply/divide execution unit sitting directly downstream of the register file: it consumes the rs1/rs2 read data and produces a result plus a write strobe that drives the register-file write port (WriteData/WriteAddr/we). It covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. Arithmetic uses a 32-step shift-add / restoring-divide datapath with a start/busy/done handshake so the single-cycle core can stall while it runs.

## Interface
- No parameters; datapath fixed at 32 bits.
- Clock/reset: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the unit can accept.
- funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  input  32  operand A, dividend.
- rs2_data  input  32  operand B, divisor.
- rd_addr  input  5  destination register, captured with the request.
- busy  output  1  high while iterating; core stalls on it.
- done  output  1  one-cycle pulse; result and rd_out valid. Drives register-file we.
- result  output  32  final value; held until the next accepted request.
- rd_out  output  5  captured rd_addr; drives register-file WriteAddr.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - CALC: busy=1, 32 iterations, 5-bit counter 0..31.
  - DONE: done=1 for exactly one cycle.
- Accept rule: start is accepted when state is IDLE or DONE. start in CALC is ignored; no queuing.
- On accept:
  - Latch funct3, rd_addr and operand magnitudes.
  - Latch the sign flags:
    - MUL/MULH: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - MULHU/DIVU/REMU: both unsigned.
    - DIV/REM: both signed.
  - Go to CALC.
- Multiply:
  - Unsigned 32x32 shift-add into a 64-bit accumulator, one multiplier bit per iteration.
  - Negate the 64-bit product if the operand signs differ.
  - MUL returns bits [31:0]; the MULH variants return bits [63:32].
- Divide:
  - Restoring division on magnitudes, one quotient bit per iteration.
  - Quotient sign = sign1 XOR sign2. Remainder sign = dividend sign.
  - Sign fix is applied on the CALC->DONE transition.
- Special cases (detected at accept; bypass CALC and go straight to DONE):
  - Divisor == 0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = rs1_data.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): DIV result 0x80000000; REM result 0.
- State transitions:
  - CALC -> DONE after the 32nd iteration.
  - DONE -> IDLE, or DONE -> CALC/DONE if start is accepted in that cycle (back-to-back issue).
- rd_out and result hold their last values in IDLE. done never asserts spontaneously.

## Timing
- Reset values: state IDLE, busy=0, done=0, result=0, rd_out=0, counter=0.
- Reset applies at the next rising edge regardless of state. A reset in CALC aborts the operation with no done pulse.
- Normal latency: start sampled at edge N.
  - busy is high for the cycles following edges N..N+31.
  - done is high for the single cycle following edge N+32.
  - Result is valid in that same done cycle: 33 cycles from request to write strobe.
- Special-case latency: done is high in the cycle following edge N (1 cycle); busy stays 0.
- Back-to-back: start in the DONE cycle is accepted with no gap. busy rises in the cycle right after done.
- Operand inputs are sampled only at accept. Changes during CALC have no effect.

## Test plan
- MUL 7 x 0xFFFFFFFD (-3) -> done exactly 33 cycles after start, result 0xFFFFFFEB, rd_out = rd_addr. MULHU of the same operands -> 0x00000006.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU -> 2.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF with done 1 cycle after start, busy never high. REMU 5/0 -> 5. Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Pulse start again during CALC with different operands -> ignored; first result is unchanged. Issue start in the DONE cycle -> second op accepted, its done arrives 33 cycles later.
- Assert rst at iteration 10 of a DIV -> the next cycle shows busy=0, done=0, result=0, and no done pulse follows. A new request after reset completes normally.
